// File: rtl/servo_dec_if.sv
// Signal bundle between a servo PWM line source and the servo_pwm_decoder.
`timescale 1ns/1ps
interface servo_dec_if;
  // No backpressure anywhere: valid and range_err are single-cycle strobes that
  // the consumer must sample on the cycle they are high; there is no ready.
  logic        pwm_in;
  logic [17:0] pulse_width;
  logic [1:0]  direction;
  logic        valid;
  logic        range_err;
  logic        timeout;
  logic [1:0]  dbg_state;

  modport master (
    output pwm_in,
    input  pulse_width, direction, valid, range_err, timeout, dbg_state
  );

  modport slave (
    input  pwm_in,
    output pulse_width, direction, valid, range_err, timeout, dbg_state
  );
endinterface

// File: rtl/servo_pwm_decoder.sv
// Measures servo PWM high time and decodes it to 00 rest / 01 left / 11 right.
// Optional glitch filter on the synchronized line: `define SERVO_DEC_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module servo_pwm_decoder #(
  parameter int unsigned MIN_PULSE     = 50000,
  parameter int unsigned MAX_PULSE     = 250000,
  parameter int unsigned LEFT_THRESH   = 175000,
  parameter int unsigned RIGHT_THRESH  = 125000,
  parameter int unsigned TIMEOUT       = 2500000,
  parameter int unsigned GLITCH_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  servo_dec_if.slave  bus
);
  typedef enum logic [1:0] {ARM = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

  localparam logic [17:0] MIN_W   = 18'(MIN_PULSE);
  localparam logic [17:0] MAX_W   = 18'(MAX_PULSE);
  localparam logic [17:0] SAT_W   = 18'(MAX_PULSE + 1);
  localparam logic [17:0] LEFT_W  = 18'(LEFT_THRESH);
  localparam logic [17:0] RIGHT_W = 18'(RIGHT_THRESH);
  localparam logic [21:0] TO_P    = 22'(TIMEOUT);
  localparam logic [21:0] TO_PM1  = 22'(TIMEOUT - 1);
  // ARM ignores the line until the reset-cleared pipeline holds real samples,
  // otherwise a line high at reset release would look like a fresh rising edge.
  localparam int unsigned SETTLE   = GLITCH_CYCLES + 4;
  localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

  logic s1_q, s2_q, line, prev_q, rise, fall;
  logic [SETTLE_W-1:0] settle_q;
  state_t state_q, state_d;
  logic [17:0] w_q, w_d;
  logic [21:0] per_q, per_d;
  logic eval, legal, bad, to_hit;
  logic [17:0] pw_q;
  logic [1:0]  dir_q;
  logic valid_q, rerr_q, to_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.pwm_in;
      s2_q <= s1_q;
    end
  end

`ifdef SERVO_DEC_GLITCH_FILTER_EN
  localparam int unsigned GW = $clog2(GLITCH_CYCLES + 1);
  logic          filt_q;
  logic [GW-1:0] run_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else if (s2_q == filt_q) begin
      run_q <= '0;
    end else if (run_q == GW'(GLITCH_CYCLES - 1)) begin
      filt_q <= s2_q;
      run_q  <= '0;
    end else begin
      run_q <= run_q + 1'b1;
    end
  end
  assign line = filt_q;
`else
  assign line = s2_q;
`endif

  assign rise = line & ~prev_q;
  assign fall = ~line & prev_q;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    eval    = 1'b0;
    case (state_q)
      ARM: begin
        w_d = '0;
        if (settle_q == SETTLE_V && !line) state_d = LOW;
      end
      LOW: begin
        if (rise) begin
          w_d     = 18'd1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          eval    = 1'b1;
          state_d = LOW;
        end else if (w_q != SAT_W) begin
          w_d = w_q + 18'd1;
        end
      end
      default: state_d = ARM;
    endcase
  end

  assign legal  = eval && (w_q >= MIN_W) && (w_q <= MAX_W);
  assign bad    = eval && !legal;
  assign per_d  = rise ? 22'd0 : ((per_q == TO_P) ? per_q : per_q + 22'd1);
  assign to_hit = !rise && (per_q == TO_PM1);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= 1'b0;
      settle_q <= '0;
      state_q  <= ARM;
      w_q      <= '0;
      per_q    <= '0;
      pw_q     <= '0;
      dir_q    <= 2'b00;
      valid_q  <= 1'b0;
      rerr_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      prev_q   <= line;
      if (settle_q != SETTLE_V) settle_q <= settle_q + 1'b1;
      state_q  <= state_d;
      w_q      <= w_d;
      per_q    <= per_d;
      valid_q  <= legal;
      rerr_q   <= bad;
      // A legal evaluation outranks a timeout landing in the same cycle.
      if (legal) begin
        pw_q  <= w_q;
        to_q  <= 1'b0;
        dir_q <= (w_q >= LEFT_W) ? 2'b01 : ((w_q <= RIGHT_W) ? 2'b11 : 2'b00);
      end else if (to_hit) begin
        to_q  <= 1'b1;
        dir_q <= 2'b00;
      end
    end
  end

  assign bus.pulse_width = pw_q;
  assign bus.direction   = dir_q;
  assign bus.valid       = valid_q;
  assign bus.range_err   = rerr_q;
  assign bus.timeout     = to_q;
  assign bus.dbg_state   = state_q;
endmodule
